fetch_instr_queue: RTL and testbench
====================================

Name: fetch_instr_queue

Overview:
- Instruction queue between the icache interface and decode.
- Buffers fetched instructions with their PC and exception info, and decouples decode stalls from icache traffic.
- Back-pressures the fetch PC generator through enq_ready_o.
- Drains on pipeline redirect via flush_i.
- Stops accepting after a faulting fetch until the fault is consumed or flushed.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- ADDR_SIZE, 40, PC width (drac_pkg ADDR_SIZE).
- INST_SIZE, 32, instruction width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  redirect; discards all entries.
- enq_valid_i  in  1  fetched instruction valid (icache interface response valid).
- enq_pc_i  in  ADDR_SIZE  PC of the fetched instruction.
- enq_inst_i  in  INST_SIZE  instruction word.
- enq_ex_i  in  exception_t  fetch exception: valid, cause, origin.
- enq_ready_o  out  1  queue accepts an enqueue this cycle.
- deq_valid_o  out  1  head entry valid toward decode.
- deq_pc_o  out  ADDR_SIZE  head PC.
- deq_inst_o  out  INST_SIZE  head instruction.
- deq_ex_o  out  exception_t  head exception.
- deq_ready_i  in  1  decode accepts the head.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage and pointers:
  - Circular buffer of DEPTH entries {pc, inst, ex}.
  - head_q and tail_q are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
  - count_q is $clog2(DEPTH)+1 bits wide.
- Handshake definitions:
  - enq_fire = enq_valid_i & enq_ready_o.
  - deq_fire = deq_valid_o & deq_ready_i.
  - enq_valid_i may drop without being accepted; the upstream stage must hold the PC while enq_ready_o=0.
- Output equations:
  - enq_ready_o = (count_q != DEPTH) & (state_q == RUN) & !flush_i & !rst_i.
  - deq_valid_o = (count_q != 0) & !flush_i.
  - deq_pc_o, deq_inst_o, deq_ex_o show the head entry when deq_valid_o=1, otherwise all zeros.
- Latency: an enqueue at edge N is visible on the deq_* outputs after edge N, i.e. 1 cycle minimum.
- Full: enq_ready_o=0, even if deq_fire occurs in the same cycle. No pass-through readiness.
- Simultaneous enq_fire and deq_fire:
  - count_q is unchanged and both pointers advance.
  - Legal at any non-full occupancy, including count_q=1, where the old head leaves and the new entry becomes head.
- FSM state_q:
  - RUN → EX_HOLD on an enq_fire with enq_ex_i.valid=1. Entries behind a fault are never accepted.
  - EX_HOLD → RUN on a deq_fire with count_q==1, i.e. the faulting entry is consumed, or on flush_i.
  - EX_HOLD holds otherwise.
  - In EX_HOLD, enq_ready_o=0.
- Flush:
  - At the next edge: count_q=0, head_q=tail_q=0, state_q=RUN.
  - Any enqueue or dequeue in the flush cycle is discarded.
  - Flush has priority over every other event.
- Reset:
  - While rst_i=1, all state is cleared asynchronously: count_q=0, pointers 0, state_q=RUN, storage zeroed.
  - Outputs under reset: enq_ready_o=0, deq_valid_o=0, deq_* zero, count_o=0.
  - enq_ready_o rises in the first cycle after rst_i deasserts.
  - Reset mid-operation drops all entries with no deq_fire.
- count_o = count_q.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined:
  - When count_q==0, state_q==RUN, flush_i=0, enq_valid_i=1 and deq_ready_i=1, the enq_* inputs drive the deq_* outputs combinationally with deq_valid_o=1.
  - The entry is not written and count_q stays 0. This applies even if enq_ex_i.valid=1, in which case state_q stays RUN.
  - deq_valid_o = (count_q != 0 | bypass_cond) & !flush_i.
- Undefined: no bypass; minimum enqueue-to-dequeue latency is 1 cycle.

Test Plan:
- Fill and drain:
  - Stimulus: deq_ready_i=0; enqueue PCs 0x1000, 0x1004, 0x1008, 0x100C.
  - Response: count_o=4, enq_ready_o=0. Then set deq_ready_i=1: four dequeues in order 0x1000..0x100C, count_o 4→0.
- Wrap-around:
  - Stimulus: 10 back-to-back enqueues, PC 0x2000+4k, with deq_ready_i=1 throughout.
  - Response: deq_pc_o sequence matches exactly; count_o stays 1 after the first edge; pointers wrap with no loss.
- Full with simultaneous dequeue:
  - Stimulus: count=4, enq_valid_i=1, deq_ready_i=1 for one cycle.
  - Response: only the dequeue fires; count_o=3 next cycle; enq_ready_o=1.
- Exception hold:
  - Stimulus: enqueue 0x3000, then 0x3004 with ex.valid=1 and cause INSTR_ACCESS_FAULT.
  - Response: enq_ready_o=0 afterwards. Dequeue both and deq_ex_o.valid=1 on 0x3004. enq_ready_o=1 in the cycle after the faulting entry is dequeued.
- Flush:
  - Stimulus: count=3, assert flush_i with enq_valid_i=1 and deq_ready_i=1.
  - Response: deq_valid_o=0 and enq_ready_o=0 in that cycle; count_o=0 next cycle; no entry is delivered.
- Async reset:
  - Stimulus: count=2, assert rst_i mid-cycle.
  - Response: count_o=0 and deq_valid_o=0 immediately, without waiting for clk_i; enq_ready_o=1 one cycle after deassert.

Source files
------------

// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: instruction queue between the icache response and decode.
// Holds {pc, inst, ex} entries in a circular buffer, back-pressures fetch via
// enq_ready_o, drains on flush_i and stops accepting after a faulting fetch
// until that fault has been consumed or flushed.
// Optional build macro: FETCH_QUEUE_BYPASS_EN (empty-queue combinational bypass).

package fetch_instr_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] cause;
    logic [63:0] origin;
  } exception_t;

  localparam logic [63:0] INSTR_ACCESS_FAULT = 64'd1;
endpackage

module fetch_instr_queue
  import fetch_instr_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_SIZE = 40,
  parameter int unsigned INST_SIZE = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   enq_valid_i,
  input  logic [ADDR_SIZE-1:0]   enq_pc_i,
  input  logic [INST_SIZE-1:0]   enq_inst_i,
  input  exception_t             enq_ex_i,
  output logic                   enq_ready_o,
  output logic                   deq_valid_o,
  output logic [ADDR_SIZE-1:0]   deq_pc_o,
  output logic [INST_SIZE-1:0]   deq_inst_o,
  output exception_t             deq_ex_o,
  input  logic                   deq_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    RUN     = 1'b0,
    EX_HOLD = 1'b1
  } state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [CNT_W-1:0]     count_q;

  logic [ADDR_SIZE-1:0] pc_q   [DEPTH];
  logic [INST_SIZE-1:0] inst_q [DEPTH];
  exception_t           ex_q   [DEPTH];

  logic bypass_cond;
  logic enq_fire;
  logic deq_fire;
  logic push;
  logic pop;

  // Full, a held fault, a flush or reset all block new fetches; no pass-through
  // readiness even when the head leaves in the same cycle.
  assign enq_ready_o = (count_q != FULL_CNT) && (state_q == RUN) && !flush_i && !rst_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue and decode ready: hand the fetched entry straight through.
  assign bypass_cond = (count_q == '0) && (state_q == RUN) && !flush_i && !rst_i &&
                       enq_valid_i && deq_ready_i;
`else
  assign bypass_cond = 1'b0;
`endif

  assign deq_valid_o = ((count_q != '0) || bypass_cond) && !flush_i;
  assign enq_fire    = enq_valid_i && enq_ready_o;
  assign deq_fire    = deq_valid_o && deq_ready_i;
  // A bypassed entry is consumed without touching storage or occupancy.
  assign push        = enq_fire && !bypass_cond;
  assign pop         = deq_fire && !bypass_cond;
  assign count_o     = count_q;

  // Head view toward decode; all zeros whenever nothing valid is presented.
  always_comb begin
    deq_pc_o   = '0;
    deq_inst_o = '0;
    deq_ex_o   = '0;
    if (bypass_cond) begin
      deq_pc_o   = enq_pc_i;
      deq_inst_o = enq_inst_i;
      deq_ex_o   = enq_ex_i;
    end else if (deq_valid_o) begin
      deq_pc_o   = pc_q[head_q];
      deq_inst_o = inst_q[head_q];
      deq_ex_o   = ex_q[head_q];
    end
  end

  // Entry storage: written at the tail on every accepted, non-bypassed fetch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        ex_q[i]   <= '0;
      end
    end else if (push) begin
      pc_q[tail_q]   <= enq_pc_i;
      inst_q[tail_q] <= enq_inst_i;
      ex_q[tail_q]   <= enq_ex_i;
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle enqueue/dequeue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Fault hold: after queueing a faulting fetch, accept nothing until it leaves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else if (flush_i) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (push && enq_ex_i.valid) state_q <= EX_HOLD;
        EX_HOLD: if (pop && (count_q == CNT_W'(1))) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// tb_fetch_instr_queue: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the fetch instruction queue.

module tb_fetch_instr_queue;
  import fetch_instr_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 40;
  localparam int IW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          ev;
  logic [AW-1:0] epc;
  logic [IW-1:0] einst;
  exception_t    eex;
  logic          er;
  logic          dv;
  logic [AW-1:0] dpc;
  logic [IW-1:0] dinst;
  exception_t    dex;
  logic          dr;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  fetch_instr_queue #(.DEPTH(DEPTH), .ADDR_SIZE(AW), .INST_SIZE(IW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .enq_valid_i (ev),
    .enq_pc_i    (epc),
    .enq_inst_i  (einst),
    .enq_ex_i    (eex),
    .enq_ready_o (er),
    .deq_valid_o (dv),
    .deq_pc_o    (dpc),
    .deq_inst_o  (dinst),
    .deq_ex_o    (dex),
    .deq_ready_i (dr),
    .count_o     (cnt)
  );

  // Reference model: an ordered list of entries plus a "fault pending" flag.
  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
    exception_t    ex;
  } ent_t;

  ent_t mq[$];
  bit   m_hold;

  int   n_tests = 0;
  int   n_fail  = 0;

  bit   x_ready;
  bit   x_valid;
  bit   x_byp;
  ent_t x_head;
  int   x_count;

  function automatic void predict();
    x_count = mq.size();
    x_ready = (mq.size() != DEPTH) && !m_hold && !flush && !rst;
`ifdef FETCH_QUEUE_BYPASS_EN
    x_byp = (mq.size() == 0) && !m_hold && !flush && !rst && ev && dr;
`else
    x_byp = 1'b0;
`endif
    x_valid = ((mq.size() != 0) || x_byp) && !flush;
    x_head.pc   = '0;
    x_head.inst = '0;
    x_head.ex   = '0;
    if (x_valid) begin
      if (x_byp) begin
        x_head.pc   = epc;
        x_head.inst = einst;
        x_head.ex   = eex;
      end else begin
        x_head = mq[0];
      end
    end
  endfunction

  function automatic void advance();
    int   old;
    ent_t e;
    if (rst || flush) begin
      mq.delete();
      m_hold = 1'b0;
      return;
    end
    if (x_byp) return;
    old = mq.size();
    if (x_valid && dr) begin
      void'(mq.pop_front());
      if (old == 1) m_hold = 1'b0;
    end
    if (ev && x_ready) begin
      e.pc = epc; e.inst = einst; e.ex = eex;
      mq.push_back(e);
      if (eex.valid) m_hold = 1'b1;
    end
  endfunction

  task automatic drive(input bit v, input logic [AW-1:0] pc, input bit exv, input bit r);
    ev          = v;
    epc         = pc;
    einst       = $urandom;
    dr          = r;
    eex.valid   = exv;
    eex.cause   = exv ? INSTR_ACCESS_FAULT : 64'd0;
    eex.origin  = exv ? 64'(pc) : 64'd0;
    #1;
    predict();
  endtask

  task automatic step();
    if (dv && dr) $display("[TB] t=%0t deq pc=%h ex=%0b count=%0d", $time, dpc, dex.valid, cnt);
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL reset_enq_ready got=%0b exp=0", er); end
    n_tests++; if (dv !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid got=%0b exp=0", dv); end
    n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", cnt); end
    n_tests++; if (dpc !== 0) begin n_fail++; $display("FAIL reset_deq_pc got=%h exp=0", dpc); end
    rst = 1'b0;
    drive(0, '0, 0, 0);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%0b exp=1", er); end
    step();
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) begin
      drive(1, AW'(32'h1000 + 4 * k), 0, 0);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL fill_ready k=%0d got=%0b exp=1", k, er); end
      step();
    end
    drive(0, '0, 0, 0);
    n_tests++; if (cnt !== 4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", cnt); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got=%0b exp=0", er); end
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, 0, 1);
      n_tests++; if (dpc !== AW'(32'h1000 + 4 * k)) begin n_fail++; $display("FAIL drain_pc k=%0d got=%h exp=%h", k, dpc, 32'h1000 + 4 * k); end
      n_tests++; if (cnt !== CW'(4 - k)) begin n_fail++; $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, cnt, 4 - k); end
      step();
    end
    drive(0, '0, 0, 0);
    n_tests++; if (cnt !== 0 || dv !== 1'b0) begin n_fail++; $display("FAIL drain_empty count=%0d valid=%0b exp 0/0", cnt, dv); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 10; k++) begin
      drive(1, AW'(32'h2000 + 4 * k), 0, 1);
      if (k > 0) begin
        n_tests++; if (dv !== 1'b1 || dpc !== AW'(32'h2000 + 4 * (k - 1))) begin
          n_fail++; $display("FAIL wrap_pc k=%0d valid=%0b got=%h exp=%h", k, dv, dpc, 32'h2000 + 4 * (k - 1));
        end
        n_tests++; if (cnt !== 1) begin n_fail++; $display("FAIL wrap_count k=%0d got=%0d exp=1", k, cnt); end
      end
      step();
    end
    drive(0, '0, 0, 1);
    n_tests++; if (dpc !== AW'(32'h2024)) begin n_fail++; $display("FAIL wrap_last_pc got=%h exp=2024", dpc); end
    step();
  endtask

  task automatic test_full_simul_deq();
    for (int k = 0; k < 4; k++) begin
      drive(1, AW'(32'h5000 + 4 * k), 0, 0);
      step();
    end
    drive(1, AW'(32'h5010), 0, 1);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL full_deq_ready got=%0b exp=0", er); end
    n_tests++; if (dv !== 1'b1 || dpc !== AW'(32'h5000)) begin n_fail++; $display("FAIL full_deq_head valid=%0b got=%h exp=5000", dv, dpc); end
    step();
    drive(0, '0, 0, 0);
    n_tests++; if (cnt !== 3) begin n_fail++; $display("FAIL full_deq_count got=%0d exp=3", cnt); end
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL full_deq_ready_after got=%0b exp=1", er); end
    for (int k = 1; k < 4; k++) begin
      drive(0, '0, 0, 1);
      n_tests++; if (dpc !== AW'(32'h5000 + 4 * k)) begin n_fail++; $display("FAIL full_drain_pc k=%0d got=%h exp=%h", k, dpc, 32'h5000 + 4 * k); end
      step();
    end
  endtask

  task automatic test_exception_hold();
    drive(1, AW'(32'h3000), 0, 0);
    step();
    drive(1, AW'(32'h3004), 1, 0);
    step();
    drive(1, AW'(32'h3008), 0, 0);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL exc_hold_ready got=%0b exp=0", er); end
    step();
    drive(0, '0, 0, 1);
    n_tests++; if (dpc !== AW'(32'h3000) || dex.valid !== 1'b0) begin n_fail++; $display("FAIL exc_first pc=%h ex=%0b exp 3000/0", dpc, dex.valid); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL exc_mid_ready got=%0b exp=0", er); end
    step();
    drive(0, '0, 0, 1);
    n_tests++; if (dpc !== AW'(32'h3004) || dex.valid !== 1'b1) begin n_fail++; $display("FAIL exc_fault pc=%h ex=%0b exp 3004/1", dpc, dex.valid); end
    n_tests++; if (dex.cause !== INSTR_ACCESS_FAULT) begin n_fail++; $display("FAIL exc_cause got=%0d exp=%0d", dex.cause, INSTR_ACCESS_FAULT); end
    step();
    drive(0, '0, 0, 0);
    n_tests++; if (er !== 1'b1 || cnt !== 0) begin n_fail++; $display("FAIL exc_release ready=%0b count=%0d exp 1/0", er, cnt); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1, AW'(32'h4000 + 4 * k), 0, 0);
      step();
    end
    flush = 1'b1;
    drive(1, AW'(32'h400C), 0, 1);
    n_tests++; if (dv !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%0b exp=0", dv); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%0b exp=0", er); end
    step();
    flush = 1'b0;
    drive(0, '0, 0, 1);
    n_tests++; if (cnt !== 0 || dv !== 1'b0) begin n_fail++; $display("FAIL flush_after count=%0d valid=%0b exp 0/0", cnt, dv); end
    step();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1, AW'(32'h6000 + 4 * k), 0, 0);
      step();
    end
    drive(0, '0, 0, 0);
    n_tests++; if (cnt !== 2) begin n_fail++; $display("FAIL areset_pre_count got=%0d exp=2", cnt); end
    rst = 1'b1;
    #1;
    n_tests++; if (cnt !== 0) begin n_fail++; $display("FAIL areset_count got=%0d exp=0", cnt); end
    n_tests++; if (dv !== 1'b0 || er !== 1'b0) begin n_fail++; $display("FAIL areset_outputs valid=%0b ready=%0b exp 0/0", dv, er); end
    mq.delete();
    m_hold = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, '0, 0, 0);
    n_tests++; if (er !== 1'b1 || cnt !== 0) begin n_fail++; $display("FAIL areset_release ready=%0b count=%0d exp 1/0", er, cnt); end
    step();
  endtask

  task automatic test_random();
    logic [AW-1:0] pc;
    for (int i = 0; i < 200; i++) begin
      pc = AW'({$urandom, $urandom});
      pc[1:0] = 2'b00;
      flush = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 3) != 0, pc, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
      n_tests++; if (er !== x_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", i, er, x_ready); end
      n_tests++; if (dv !== x_valid) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, dv, x_valid); end
      n_tests++; if (dpc !== x_head.pc) begin n_fail++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, dpc, x_head.pc); end
      n_tests++; if (dinst !== x_head.inst) begin n_fail++; $display("FAIL rnd_inst cyc=%0d got=%h exp=%h", i, dinst, x_head.inst); end
      n_tests++; if (dex !== x_head.ex) begin n_fail++; $display("FAIL rnd_ex cyc=%0d got=%h exp=%h", i, dex, x_head.ex); end
      n_tests++; if (cnt !== CW'(x_count)) begin n_fail++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, cnt, x_count); end
      step();
    end
    flush = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    ev    = 1'b0;
    dr    = 1'b0;
    epc   = '0;
    einst = '0;
    eex   = '0;
    m_hold = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul_deq();
    test_exception_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
